// File: rtl/vex_bus_pkg.sv
// Shared encodings for the VexRiscv / debug bus bridge.
package vex_bus_pkg;

    // Which master owns the transaction currently on the memory bus.
    typedef enum logic [1:0] {
        OWN_I   = 2'd0,
        OWN_D   = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;

    // Bridge sequencing: IDLE accepts a grant, WAIT counts down to the response cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Supported memory read latency range and the counter width that covers it.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 3;
    localparam int CNT_W       = 2;

endpackage

// File: rtl/vex_bus_bridge_prio_enc.sv
// Fixed-priority grant encoder: debug beats dBus beats iBus.
module bus_prio_enc
    import vex_bus_pkg::*;
(
    input  logic   req_dbg,
    input  logic   req_d,
    input  logic   req_i,
    output logic   grant,
    output owner_t owner
);

    // Pick the highest-priority active requester.
    always_comb begin
        grant = 1'b0;
        owner = OWN_I;
        if (req_dbg) begin
            grant = 1'b1;
            owner = OWN_DBG;
        end else if (req_d) begin
            grant = 1'b1;
            owner = OWN_D;
        end else if (req_i) begin
            grant = 1'b1;
            owner = OWN_I;
        end
    end

endmodule

// File: rtl/vex_bus_bridge.sv
// Non-preemptive arbiter putting iBus, dBus and the debug port onto one memory bus,
// with responses timed to a fixed memory read latency.
module vex_bus_bridge
    import vex_bus_pkg::*;
#(
    parameter int MEM_LAT = 1,   // legal range MEM_LAT_MIN..MEM_LAT_MAX
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_run,
    input  logic              cpu_n_reset,
    input  logic              icmd_valid,
    input  logic [ADDR_W-1:0] icmd_adr,
    output logic              icmd_ready,
    output logic              irsp_valid,
    output logic [31:0]       irsp_inst,
    input  logic              dcmd_valid,
    input  logic              dcmd_wr,
    input  logic [3:0]        dcmd_mask,
    input  logic [ADDR_W-1:0] dcmd_adr,
    input  logic [31:0]       dcmd_data,
    output logic              dcmd_ready,
    output logic              drsp_valid,
    output logic [31:0]       drsp_data,
    input  logic              dbg_mem_op,
    input  logic [ADDR_W-1:0] dbg_adr,
    input  logic [31:0]       dbg_do,
    input  logic [3:0]        dbg_wren,
    output logic              dbg_mem_rdy,
    output logic [31:0]       dbg_di,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_di,
    output logic [3:0]        mem_wren,
    input  logic [31:0]       mem_do
);

    state_t             state_reg, state_next;
    owner_t             owner_reg, owner_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               armed_reg, armed_next;    // debug may issue one access
    logic               wr_reg, wr_next;          // dBus transaction is a write
    logic               killed_reg, killed_next;  // CPU was reset during this transaction

    logic               grant;
    owner_t             grant_owner;
    logic               cpu_ok;
    logic               cpu_kill;

    assign cpu_ok   = cpu_run && cpu_n_reset;
    // Any sight of cpu_n_reset low while the transaction is open drops the CPU response.
    assign cpu_kill = killed_reg || !cpu_n_reset;

    bus_prio_enc u_prio (
        .req_dbg (dbg_mem_op && armed_reg),
        .req_d   (dcmd_valid && cpu_ok),
        .req_i   (icmd_valid && cpu_ok),
        .grant   (grant),
        .owner   (grant_owner)
    );

    // State, owner, latency counter and debug arming registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= OWN_I;
            cnt_reg    <= '0;
            armed_reg  <= 1'b1;
            wr_reg     <= 1'b0;
            killed_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
            armed_reg  <= armed_next;
            wr_reg     <= wr_next;
            killed_reg <= killed_next;
        end
    end

    // Grant muxing in IDLE, countdown and single-cycle response pulses in WAIT.
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        cnt_next    = cnt_reg;
        armed_next  = armed_reg || !dbg_mem_op;
        wr_next     = wr_reg;
        killed_next = killed_reg;

        icmd_ready  = 1'b0;
        irsp_valid  = 1'b0;
        irsp_inst   = '0;
        dcmd_ready  = 1'b0;
        drsp_valid  = 1'b0;
        drsp_data   = '0;
        dbg_mem_rdy = 1'b0;
        dbg_di      = '0;
        mem_op      = 1'b0;
        mem_adr     = '0;
        mem_di      = '0;
        mem_wren    = '0;

        case (state_reg)
            ST_IDLE: begin
                // Reset gating keeps the bus quiet while n_reset is held low.
                if (grant && n_reset) begin
                    mem_op      = 1'b1;
                    owner_next  = grant_owner;
                    cnt_next    = CNT_W'(MEM_LAT - 1);
                    wr_next     = 1'b0;
                    killed_next = 1'b0;
                    state_next  = ST_WAIT;
                    case (grant_owner)
                        OWN_DBG: begin
                            mem_adr  = dbg_adr;
                            mem_di   = dbg_do;
                            mem_wren = dbg_wren;
                        end
                        OWN_D: begin
                            mem_adr    = dcmd_adr;
                            mem_di     = dcmd_data;
                            mem_wren   = dcmd_wr ? dcmd_mask : 4'h0;
                            dcmd_ready = 1'b1;
                            wr_next    = dcmd_wr;
                        end
                        default: begin
                            mem_adr    = icmd_adr;
                            icmd_ready = 1'b1;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                killed_next = killed_reg || !cpu_n_reset;
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    case (owner_reg)
                        OWN_DBG: begin
                            dbg_mem_rdy = 1'b1;
                            dbg_di      = mem_do;
                            armed_next  = 1'b0;
                        end
                        OWN_D: begin
                            if (!wr_reg && !cpu_kill) begin
                                drsp_valid = 1'b1;
                                drsp_data  = mem_do;
                            end
                        end
                        default: begin
                            if (!cpu_kill) begin
                                irsp_valid = 1'b1;
                                irsp_inst  = mem_do;
                            end
                        end
                    endcase
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
